// File: rtl/ahblite_pkg.sv
// Shared encodings for the AHB-Lite timer: bus codes, register map, error FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ahblite_pkg;

  // HTRANS / HRESP encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Word offsets (HADDR[4:2])
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_LOAD     = 3'd1;
  localparam logic [2:0] OFF_VALUE    = 3'd2;
  localparam logic [2:0] OFF_PRESCALE = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  // CTRL / STATUS bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int STATUS_IF    = 0;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR_ONE  = 2'd1,
    ERR_TWO  = 2'd2
  } err_state_t;

  // Registered address-phase information carried into the data phase
  typedef struct packed {
    logic       vld;
    logic       write;
    logic [2:0] off;
    logic [3:0] strb;
  } dphase_t;

  function automatic logic is_mapped(input logic [2:0] off);
    return off <= OFF_STATUS;
  endfunction

  // Little-endian byte lanes from HSIZE and the low address bits
  function automatic logic [3:0] byte_strb(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] strb;
    case (size)
      3'd0:    strb = 4'b0001 << addr;
      3'd1:    strb = addr[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] cur, input logic [31:0] wdat,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdat[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ahblite_timer_core.sv
// Prescaler plus 32-bit reload down-counter; flags the underflow tick and one-shot stop.
// Latency: VALUE updates on the edge that ends a tick cycle; if_set/en_clr are combinational in that cycle.
// Backpressure: none; a value write always wins over a tick in the same cycle.
// Ports: clk/rst (sync, active-high); en, en_start, oneshot, load, prescale from the register file;
//        val_wr/val_wdat direct VALUE load; value, if_set, en_clr back to the register file.
module ahblite_timer_core #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  en_start,
  input  logic                  oneshot,
  input  logic [31:0]           load,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  val_wr,
  input  logic [31:0]           val_wdat,
  output logic [31:0]           value,
  output logic                  if_set,
  output logic                  en_clr
);

  logic [PRESCALE_W-1:0] ps_cnt;
  logic                  tick;

  // Equality compare only: if PRESCALE is lowered below the running count, the
  // counter runs on and wraps through 2^PRESCALE_W before the next tick.
  assign tick   = en && (ps_cnt == prescale);
  assign if_set = tick && (value == 32'd0);
  assign en_clr = if_set && oneshot;

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_cnt <= '0;
      value  <= '0;
    end else begin
      if (!en || en_start || tick) ps_cnt <= '0;
      else                         ps_cnt <= ps_cnt + PRESCALE_W'(1);

      if (val_wr) begin
        value <= val_wdat;
      end else if (tick) begin
        if (value != 32'd0) value <= value - 32'd1;
        else if (!oneshot)  value <= load;
      end
    end
  end

endmodule

// File: rtl/ahblite_timer.sv
// AHB-Lite timer slave: register file, bus pipeline and two-cycle ERROR FSM around the timer core.
// Latency: zero wait states on mapped offsets; unmapped offsets take two data-phase cycles (ERROR).
// Backpressure: HREADYOUT low only in the first ERROR cycle; otherwise always ready.
// Ports: HCLK/HRESET (sync, active-high); AHB-Lite slave inputs HSEL..HREADY;
//        HREADYOUT/HRDATA/HRESP slave response; IRQ level interrupt (IF & IE).
module ahblite_timer
  import ahblite_pkg::*;
#(
  parameter bit ERR_ON_UNMAPPED = 1'b1,
  parameter int PRESCALE_W      = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        IRQ
);

  dphase_t               dp;
  err_state_t            err_state;
  logic                  hreadyout_q, hresp_q;
  logic                  ctrl_en, ctrl_ie, ctrl_oneshot, if_q;
  logic [31:0]           load_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [31:0]           value;
  logic                  if_set, en_clr;

  logic                  accept, a_err;
  logic [2:0]            a_off;
  logic [31:0]           cur_dat, wr_dat;
  logic                  wr_act, wr_ctrl, wr_load, wr_value, wr_prescale, wr_status;
  logic                  w1c, en_start;

  logic unused_bits;
  assign unused_bits = ^{HPROT, HADDR[31:5], HTRANS[0]};

  // Address phase
  assign accept = HSEL && HREADY && HTRANS[1];
  assign a_off  = HADDR[4:2];
  assign a_err  = accept && ERR_ON_UNMAPPED && !is_mapped(a_off);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp <= '0;
    end else begin
      dp.vld <= accept;
      if (accept) begin
        dp.write <= HWRITE;
        dp.off   <= a_off;
        dp.strb  <= byte_strb(HSIZE, HADDR[1:0]);
      end
    end
  end

  // Current contents of the register addressed in the data phase; also the
  // base that byte-lane writes merge into.
  always_comb begin
    cur_dat = '0;
    case (dp.off)
      OFF_CTRL: begin
        cur_dat[CTRL_EN]      = ctrl_en;
        cur_dat[CTRL_IE]      = ctrl_ie;
        cur_dat[CTRL_ONESHOT] = ctrl_oneshot;
      end
      OFF_LOAD:     cur_dat = load_q;
      OFF_VALUE:    cur_dat = value;
      OFF_PRESCALE: cur_dat[PRESCALE_W-1:0] = prescale_q;
      OFF_STATUS:   cur_dat[STATUS_IF] = if_q;
      default:      cur_dat = '0;
    endcase
  end

  assign HRDATA = (dp.vld && !dp.write) ? cur_dat : 32'd0;
  assign wr_dat = apply_strb(cur_dat, HWDATA, dp.strb);

  // Unmapped writes never reach a register regardless of ERR_ON_UNMAPPED
  assign wr_act      = dp.vld && dp.write && is_mapped(dp.off);
  assign wr_ctrl     = wr_act && (dp.off == OFF_CTRL);
  assign wr_load     = wr_act && (dp.off == OFF_LOAD);
  assign wr_value    = wr_act && (dp.off == OFF_VALUE);
  assign wr_prescale = wr_act && (dp.off == OFF_PRESCALE);
  assign wr_status   = wr_act && (dp.off == OFF_STATUS);
  assign w1c         = wr_status && dp.strb[0] && HWDATA[STATUS_IF];
  assign en_start    = wr_ctrl && wr_dat[CTRL_EN] && !ctrl_en;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl_en      <= 1'b0;
      ctrl_ie      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      load_q       <= '0;
      prescale_q   <= '0;
      if_q         <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en      <= wr_dat[CTRL_EN];
        ctrl_ie      <= wr_dat[CTRL_IE];
        ctrl_oneshot <= wr_dat[CTRL_ONESHOT];
      end else if (en_clr) begin
        ctrl_en <= 1'b0;
      end
      if (wr_load)     load_q     <= wr_dat;
      if (wr_prescale) prescale_q <= wr_dat[PRESCALE_W-1:0];
      // A tick setting IF outranks a same-cycle clear so no event is lost
      if (if_set)   if_q <= 1'b1;
      else if (w1c) if_q <= 1'b0;
    end
  end

  assign IRQ = if_q && ctrl_ie;

  // Error response: ERR_ONE stalls with ERROR, ERR_TWO completes with ERROR.
  // HREADY is high in ERR_TWO so a following transfer is accepted there.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_state   <= ERR_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (err_state)
        ERR_ONE: begin
          err_state   <= ERR_TWO;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          if (a_err) begin
            err_state   <= ERR_ONE;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
          end else begin
            err_state   <= ERR_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

  ahblite_timer_core #(.PRESCALE_W(PRESCALE_W)) u_core (
    .clk      (HCLK),
    .rst      (HRESET),
    .en       (ctrl_en),
    .en_start (en_start),
    .oneshot  (ctrl_oneshot),
    .load     (load_q),
    .prescale (prescale_q),
    .val_wr   (wr_value),
    .val_wdat (wr_dat),
    .value    (value),
    .if_set   (if_set),
    .en_clr   (en_clr)
  );

endmodule

// File: tb/tb_ahblite_timer.sv
// Directed bench for ahblite_timer: pipelined AHB master driver plus per-feature tests.
// Latency: n/a.
// Backpressure: the driver holds address/data while HREADYOUT is low, bounded per transfer.
module tb_ahblite_timer;

  logic        HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, IRQ;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;

  int checks = 0;
  int errors = 0;

  logic        op_wr    [8];
  logic [31:0] op_addr  [8];
  logic [2:0]  op_size  [8];
  logic [31:0] op_wdat  [8];
  logic [31:0] res_rdat [8];
  logic        res_resp [8];
  logic        res_wresp[8];
  int          res_waits[8];

  assign HREADY = HREADYOUT;

  ahblite_timer #(.ERR_ON_UNMAPPED(1'b1), .PRESCALE_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .IRQ(IRQ)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic set_op(input int i, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdat);
    op_wr[i] = wr; op_addr[i] = addr; op_size[i] = size; op_wdat[i] = wdat;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'd2;
  endtask

  // Back-to-back transfers op[0..n-1]; entered and left at posedge+#1
  task automatic run(input int n);
    int waits;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = op_wr[0]; HADDR = op_addr[0]; HSIZE = op_size[0];
    @(posedge HCLK); #1;
    for (int i = 0; i < n; i++) begin
      HWDATA = op_wr[i] ? op_wdat[i] : 32'd0;
      if (i + 1 < n) begin
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = op_wr[i+1]; HADDR = op_addr[i+1]; HSIZE = op_size[i+1];
      end else begin
        bus_idle();
      end
      waits = 0;
      res_wresp[i] = 1'b0;
      forever begin
        @(negedge HCLK);
        if (HREADYOUT) begin
          res_rdat[i] = HRDATA;
          res_resp[i] = HRESP;
          @(posedge HCLK); #1;
          break;
        end
        res_wresp[i] = HRESP;
        waits++;
        @(posedge HCLK); #1;
        if (waits > 4) begin
          errors++;
          $display("FAIL bus_timeout op %0d: waits %0d, required at most 4", i, waits);
          break;
        end
      end
      res_waits[i] = waits;
    end
  endtask

  task automatic test_reset();
    checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b required 1", HREADYOUT); end
    checks++; if (HRESP !== 1'b0)     begin errors++; $display("FAIL reset_hresp: got %b required 0", HRESP); end
    checks++; if (IRQ !== 1'b0)       begin errors++; $display("FAIL reset_irq: got %b required 0", IRQ); end
    checks++; if (HRDATA !== 32'd0)   begin errors++; $display("FAIL reset_hrdata: got %h required 0", HRDATA); end
    for (int i = 0; i < 5; i++) set_op(i, 1'b0, 32'(4 * i), 3'd2, 32'd0);
    run(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_rdat[i] !== 32'd0 || res_resp[i] !== 1'b0) begin
        errors++; $display("FAIL reset_read_%0d: got %h resp %b required 0 resp 0", 4 * i, res_rdat[i], res_resp[i]);
      end
    end
  endtask

  // LOAD=3, PRESCALE=1, VALUE=3, EN|IE: IF every 8 cycles from the enable edge
  task automatic test_periodic();
    set_op(0, 1'b1, 32'h04, 3'd2, 32'd3);
    set_op(1, 1'b1, 32'h0C, 3'd2, 32'd1);
    set_op(2, 1'b1, 32'h08, 3'd2, 32'd3);
    set_op(3, 1'b1, 32'h00, 3'd2, 32'h3);
    run(4);
    repeat (7) @(posedge HCLK); #1;
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL periodic_irq_c7: got %b required 0", IRQ); end
    @(posedge HCLK); #1;
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL periodic_irq_c8: got %b required 1", IRQ); end
    set_op(0, 1'b0, 32'h08, 3'd2, 32'd0);
    run(1);
    checks++; if (res_rdat[0] !== 32'd3) begin errors++; $display("FAIL periodic_reload: got %h required 3", res_rdat[0]); end
    set_op(0, 1'b1, 32'h10, 3'd2, 32'd1);
    run(1);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL periodic_w1c: got %b required 0", IRQ); end
    repeat (3) @(posedge HCLK); #1;
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL periodic_irq_c15: got %b required 0", IRQ); end
    @(posedge HCLK); #1;
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL periodic_irq_c16: got %b required 1", IRQ); end
  endtask

  task automatic test_oneshot();
    set_op(0, 1'b1, 32'h00, 3'd2, 32'h0);
    set_op(1, 1'b1, 32'h10, 3'd2, 32'h1);
    set_op(2, 1'b1, 32'h04, 3'd2, 32'd2);
    set_op(3, 1'b1, 32'h0C, 3'd2, 32'd0);
    set_op(4, 1'b1, 32'h08, 3'd2, 32'd2);
    set_op(5, 1'b1, 32'h00, 3'd2, 32'h7);
    run(6);
    repeat (2) @(posedge HCLK); #1;
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL oneshot_irq_c2: got %b required 0", IRQ); end
    @(posedge HCLK); #1;
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL oneshot_irq_c3: got %b required 1", IRQ); end
    set_op(0, 1'b0, 32'h00, 3'd2, 32'd0);
    set_op(1, 1'b0, 32'h08, 3'd2, 32'd0);
    run(2);
    checks++; if (res_rdat[0] !== 32'h6) begin errors++; $display("FAIL oneshot_ctrl: got %h required 6", res_rdat[0]); end
    checks++; if (res_rdat[1] !== 32'h0) begin errors++; $display("FAIL oneshot_value: got %h required 0", res_rdat[1]); end
  endtask

  task automatic test_byte_lanes();
    set_op(0, 1'b1, 32'h04, 3'd2, 32'h11223344);
    set_op(1, 1'b1, 32'h05, 3'd0, 32'h0000AA00);
    set_op(2, 1'b0, 32'h04, 3'd2, 32'd0);
    set_op(3, 1'b1, 32'h06, 3'd1, 32'hBEEF0000);
    set_op(4, 1'b0, 32'h04, 3'd2, 32'd0);
    run(5);
    checks++; if (res_rdat[2] !== 32'h1122AA44) begin errors++; $display("FAIL byte_write: got %h required 1122aa44", res_rdat[2]); end
    checks++; if (res_rdat[4] !== 32'hBEEFAA44) begin errors++; $display("FAIL half_write: got %h required beefaa44", res_rdat[4]); end
  endtask

  // EN is 0 here (one-shot stopped), so VALUE holds what is written
  task automatic test_back_to_back_error();
    set_op(0, 1'b1, 32'h08, 3'd2, 32'h55);
    set_op(1, 1'b1, 32'h1C, 3'd2, 32'hFFFFFFFF);
    set_op(2, 1'b0, 32'h18, 3'd2, 32'd0);
    set_op(3, 1'b0, 32'h08, 3'd2, 32'd0);
    set_op(4, 1'b0, 32'h04, 3'd2, 32'd0);
    run(5);
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (res_waits[i] !== 1 || res_wresp[i] !== 1'b1 || res_resp[i] !== 1'b1) begin
        errors++; $display("FAIL err_resp_op%0d: waits %0d resp %b/%b required waits 1 resp 1/1",
                           i, res_waits[i], res_wresp[i], res_resp[i]);
      end
    end
    checks++; if (res_rdat[2] !== 32'd0) begin errors++; $display("FAIL err_rdata: got %h required 0", res_rdat[2]); end
    checks++;
    if (res_resp[3] !== 1'b0 || res_waits[3] !== 0 || res_rdat[3] !== 32'h55) begin
      errors++; $display("FAIL err2_next_read: got %h resp %b waits %0d required 55 resp 0 waits 0",
                         res_rdat[3], res_resp[3], res_waits[3]);
    end
    checks++; if (res_rdat[4] !== 32'hBEEFAA44) begin errors++; $display("FAIL err_write_side_effect: got %h required beefaa44", res_rdat[4]); end
  endtask

  // LOAD=0, PRESCALE=0, EN only: every cycle is a tick that sets IF
  task automatic test_simultaneous();
    set_op(0, 1'b1, 32'h00, 3'd2, 32'h0);
    set_op(1, 1'b1, 32'h10, 3'd2, 32'h1);
    set_op(2, 1'b1, 32'h04, 3'd2, 32'd0);
    set_op(3, 1'b1, 32'h0C, 3'd2, 32'd0);
    set_op(4, 1'b1, 32'h08, 3'd2, 32'd0);
    set_op(5, 1'b1, 32'h00, 3'd2, 32'h1);
    run(6);
    set_op(0, 1'b1, 32'h10, 3'd2, 32'h1);
    set_op(1, 1'b0, 32'h10, 3'd2, 32'd0);
    set_op(2, 1'b1, 32'h08, 3'd2, 32'h10);
    set_op(3, 1'b0, 32'h08, 3'd2, 32'd0);
    run(4);
    checks++; if (res_rdat[1] !== 32'h1)  begin errors++; $display("FAIL sim_w1c_vs_tick: got %h required 1", res_rdat[1]); end
    checks++; if (res_rdat[3] !== 32'h10) begin errors++; $display("FAIL sim_value_vs_tick: got %h required 10", res_rdat[3]); end
    checks++; if (IRQ !== 1'b0)           begin errors++; $display("FAIL sim_irq_masked: got %b required 0", IRQ); end
  endtask

  task automatic test_reset_mid_error();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h14; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    checks++;
    if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin
      errors++; $display("FAIL rst_err1: hreadyout %b hresp %b required 0 1", HREADYOUT, HRESP);
    end
    HRESET = 1'b1; bus_idle();
    @(posedge HCLK); #1;
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      errors++; $display("FAIL rst_mid_err: hreadyout %b hresp %b required 1 0", HREADYOUT, HRESP);
    end
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      errors++; $display("FAIL rst_after_err: hreadyout %b hresp %b required 1 0", HREADYOUT, HRESP);
    end
    set_op(0, 1'b0, 32'h08, 3'd2, 32'd0);
    run(1);
    checks++; if (res_rdat[0] !== 32'd0) begin errors++; $display("FAIL rst_value: got %h required 0", res_rdat[0]); end
  endtask

  initial begin
    HRESET = 1'b1; HPROT = 4'h0; HWDATA = '0;
    bus_idle();
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_byte_lanes();
    test_back_to_back_error();
    test_simultaneous();
    test_reset_mid_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
